// File: rtl/uart_pkg.sv
// Shared types and oversampling constants for the UART transceiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int         OS_RATE    = 16;
  localparam logic [3:0] TICK_LAST  = 4'(OS_RATE - 1);
  localparam logic [3:0] TICK_EARLY = 4'd7;
  localparam logic [3:0] TICK_MID   = 4'd8;
  localparam logic [3:0] TICK_LATE  = 4'd9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator shared by the TX and RX paths.
// The divider is re-latched at each wrap so a baud_div change never truncates a period.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_div,
  output logic        os_tick
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;

  assign os_tick = (cnt_q == div_q);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    div_d = div_q;
    if (os_tick) begin
      cnt_d = '0;
      div_d = baud_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART, 16x oversampled, independent TX and RX FSMs on one tick source.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even).
//   state  | meaning
//   IDLE   | TX: ready for a payload / RX: waiting for a falling edge
//   START  | start bit (RX rejects it if high at tick 8)
//   DATA   | payload bits, LSB first
//   PARITY | parity bit (only reachable with UART_PARITY_EN)
//   STOP   | TX: STOP_BITS stop bits / RX: first stop bit up to its midpoint
module uart_xcvr #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  import uart_pkg::*;

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic os_tick;

  uart_baud_gen u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_div (baud_div),
    .os_tick  (os_tick)
  );

  uart_state_e          tx_st_q, tx_st_d;
  logic [3:0]           tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d, tx_q, tx_d, tx_rdy_q, tx_rdy_d;
  logic                 tx_bit_end;

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_bit_end = os_tick && (tx_tick_q == TICK_LAST);
    if (tx_st_q != ST_IDLE && os_tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_st_q)
      ST_IDLE: if (tx_valid && tx_rdy_q) begin
        tx_st_d   = ST_START;
        tx_sh_d   = tx_data;
        tx_par_d  = (^tx_data) ^ PAR_ODD;
        tx_tick_d = '0;
        tx_bit_d  = '0;
      end
      ST_START: if (tx_bit_end) tx_st_d = ST_DATA;
      ST_DATA: if (tx_bit_end) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_bit_q == LAST_DATA) begin
          tx_bit_d = '0;
          tx_st_d  = PAR_EN ? ST_PARITY : ST_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end
      ST_PARITY: if (tx_bit_end) tx_st_d = ST_STOP;
      ST_STOP: if (tx_bit_end) begin
        if (tx_bit_q == LAST_STOP) tx_st_d = ST_IDLE;
        else tx_bit_d = tx_bit_q + 4'd1;
      end
      default: tx_st_d = ST_IDLE;
    endcase
    // Line level is registered from the next state so tx changes with the transition edge.
    case (tx_st_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_sh_d[0];
      ST_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
    tx_rdy_d = (tx_st_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= ST_IDLE;
      tx_tick_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_rdy_q  <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_tick_q <= tx_tick_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_q      <= tx_d;
      tx_rdy_q  <= tx_rdy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_rdy_q;

  logic                 rx_meta_q, rx_s_q;
  uart_state_e          rx_st_q, rx_st_d;
  logic [3:0]           rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [1:0]           rx_vote_q, rx_vote_d;
  logic                 rx_pend_q, rx_pend_d, rx_vld_q, rx_vld_d;
  logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic                 rx_bit_val, rx_at_late, rx_at_last;

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_vote_d  = rx_vote_q;
    rx_pend_d  = rx_pend_q;
    rx_data_d  = rx_data_q;
    rx_vld_d   = 1'b0;
    rx_perr_d  = 1'b0;
    rx_ferr_d  = 1'b0;
    rx_bit_val = majority3(rx_vote_q[1], rx_vote_q[0], rx_s_q);
    rx_at_late = os_tick && (rx_tick_q == TICK_LATE);
    rx_at_last = os_tick && (rx_tick_q == TICK_LAST);
    if (rx_st_q != ST_IDLE && os_tick) begin
      rx_tick_d = rx_tick_q + 4'd1;
      if (rx_tick_q == TICK_EARLY) rx_vote_d[1] = rx_s_q;
      if (rx_tick_q == TICK_MID)   rx_vote_d[0] = rx_s_q;
    end
    case (rx_st_q)
      ST_IDLE: begin
        rx_tick_d = '0;
        rx_bit_d  = '0;
        if (!rx_s_q) rx_st_d = ST_START;
      end
      ST_START: begin
        if (os_tick && rx_tick_q == TICK_MID && rx_s_q) rx_st_d = ST_IDLE;
        else if (rx_at_last) rx_st_d = ST_DATA;
      end
      ST_DATA: begin
        if (rx_at_late) rx_sh_d = {rx_bit_val, rx_sh_q[DATA_BITS-1:1]};
        if (rx_at_last) begin
          if (rx_bit_q == LAST_DATA) begin
            rx_bit_d = '0;
            rx_st_d  = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (rx_at_late) rx_pend_d = rx_bit_val ^ (^rx_sh_q) ^ PAR_ODD;
        if (rx_at_last) rx_st_d = ST_STOP;
      end
      // Completing at the stop midpoint lets RX re-arm before the next start edge.
      ST_STOP: if (rx_at_late) begin
        rx_st_d   = ST_IDLE;
        rx_vld_d  = 1'b1;
        rx_data_d = rx_sh_q;
        rx_ferr_d = ~rx_bit_val;
        rx_perr_d = PAR_EN & rx_pend_q;
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_st_q   <= ST_IDLE;
      rx_tick_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_vote_q <= '0;
      rx_pend_q <= 1'b0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_st_q   <= rx_st_d;
      rx_tick_q <= rx_tick_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_vote_q <= rx_vote_d;
      rx_pend_q <= rx_pend_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      rx_perr_q <= rx_perr_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_vld_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed + randomized bench for uart_xcvr (DATA_BITS=8, STOP_BITS=2).
// Expected frames come from a bit-level frame model; RX results are collected by a monitor.
module tb_uart_xcvr;
  localparam int DB = 8;
  localparam int SB = 2;
  localparam int PO = 0;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = 1 + DB + PB + SB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   baud_div = 16'd0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx;
  logic          rx_drv = 1'b1;
  logic          loop_en = 1'b1;
  logic          rx_line;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_parity_err, rx_frame_err;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_xcvr #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_div      (baud_div),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .rx            (rx_line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int flag_viol = 0;
  logic [DB-1:0] rxd_q[$];
  logic          rxp_q[$];
  logic          rxf_q[$];
  int            acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rst_n && tx_valid && tx_ready) acc_q.push_back(cyc);

  always @(negedge clk) begin
    if (rx_valid) begin
      rxd_q.push_back(rx_data);
      rxp_q.push_back(rx_parity_err);
      rxf_q.push_back(rx_frame_err);
    end else if (rx_parity_err || rx_frame_err) begin
      flag_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: bit k of the serial frame for payload d.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (PB == 1 && k == DB + 1) return 1'(($countones(d) + PO) % 2);
    return 1'b1;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DB-1:0] d, input bit hold, output int t0);
    int n0;
    int b;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    n0 = acc_q.size();
    b = 0;
    while (acc_q.size() == n0 && b < 3000) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("tx_accept", acc_q.size(), n0 + 1);
    t0 = (acc_q.size() > n0) ? acc_q[n0] + 1 : cyc;
    if (!hold) begin
      tx_valid = 1'b0;
      tx_data  = DB'($urandom);
    end
  endtask

  task automatic check_tx(input logic [DB-1:0] d, input int t0, input int bd);
    int p;
    p = 16 * (bd + 1);
    for (int k = 0; k < FLEN; k++) begin
      if (bd == 0) begin
        wait_until(t0 + 16 * k);
        check($sformatf("tx_bit%0d_first", k), tx, frame_bit(d, k));
        wait_until(t0 + 16 * k + 15);
        check($sformatf("tx_bit%0d_last", k), tx, frame_bit(d, k));
      end else begin
        wait_until(t0 + k * p + p / 2);
        check($sformatf("tx_bit%0d_mid", k), tx, frame_bit(d, k));
      end
    end
  endtask

  task automatic drive_rx(input logic [DB-1:0] d, input bit flip_par, input bit stop_low, input int bd);
    logic b;
    for (int k = 0; k < FLEN; k++) begin
      b = frame_bit(d, k);
      if (flip_par && PB == 1 && k == DB + 1) b = ~b;
      if (stop_low && k == DB + PB + 1) b = 1'b0;
      rx_drv = b;
      repeat (16 * (bd + 1)) @(posedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input int n);
    int b;
    b = 0;
    while (rxd_q.size() < n && b < 4000) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("rx_count", rxd_q.size(), n);
  endtask

  task automatic check_rx(input int idx, input logic [DB-1:0] d, input logic pe, input logic fe);
    if (rxd_q.size() > idx) begin
      check("rx_data", rxd_q[idx], d);
      check("rx_parity_err", rxp_q[idx], pe);
      check("rx_frame_err", rxf_q[idx], fe);
    end else begin
      check("rx_missing", rxd_q.size(), idx + 1);
    end
  endtask

  initial begin
    int t0, t1, nrx, bd;
    logic [DB-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check("rst_perr", rx_parity_err, 1'b0);
    check("rst_ferr", rx_frame_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", tx_ready, 1'b1);

    nrx = 0;
    send(8'hA5, 1'b0, t0);
    check_tx(8'hA5, t0, 0);
    nrx++;
    wait_rx(nrx);
    check_rx(nrx - 1, 8'hA5, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      bd = $urandom_range(0, 3);
      baud_div = 16'(bd);
      repeat (20) @(posedge clk);
      d = DB'($urandom);
      send(d, 1'b0, t0);
      check_tx(d, t0, bd);
      nrx++;
      wait_rx(nrx);
      check_rx(nrx - 1, d, 1'b0, 1'b0);
    end
    repeat (50) @(posedge clk);
    #1;
    check("rx_data_hold", rx_data, d);

    baud_div = 16'd0;
    repeat (20) @(posedge clk);
    loop_en = 1'b0;
    @(negedge clk) rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_no_valid", rxd_q.size(), nrx);

    baud_div = 16'd1;
    repeat (20) @(posedge clk);
    d = DB'($urandom);
    drive_rx(d, 1'b0, 1'b0, 1);
    nrx++;
    wait_rx(nrx);
    check_rx(nrx - 1, d, 1'b0, 1'b0);

    repeat (40) @(posedge clk);
    drive_rx(8'h3C, 1'b0, 1'b1, 1);
    nrx++;
    wait_rx(nrx);
    check_rx(nrx - 1, 8'h3C, 1'b0, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    check("ferr_no_extra", rxd_q.size(), nrx);

`ifdef UART_PARITY_EN
    baud_div = 16'd0;
    loop_en = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h07, 1'b0, t0);
    check_tx(8'h07, t0, 0);
    nrx++;
    wait_rx(nrx);
    check_rx(nrx - 1, 8'h07, 1'b0, 1'b0);
    loop_en = 1'b0;
    repeat (20) @(posedge clk);
    drive_rx(8'h07, 1'b1, 1'b0, 0);
    nrx++;
    wait_rx(nrx);
    check_rx(nrx - 1, 8'h07, 1'b1, 1'b0);
`endif

    baud_div = 16'd0;
    loop_en = 1'b1;
    repeat (40) @(posedge clk);
    send(8'h00, 1'b1, t0);
    tx_data = 8'hFF;
    t1 = 0;
    while (acc_q.size() < 2 + nrx + 0 && t1 < 0) t1++;
    begin
      int n0, b;
      n0 = acc_q.size();
      b = 0;
      while (acc_q.size() == n0 && b < 1000) begin
        @(posedge clk);
        #1;
        b++;
      end
      check("b2b_second_accept", acc_q.size(), n0 + 1);
      if (acc_q.size() > n0) check("b2b_gap", acc_q[n0] + 1 - t0, 16 * FLEN + 1);
    end
    tx_valid = 1'b0;
    nrx += 2;
    wait_rx(nrx);
    check_rx(nrx - 2, 8'h00, 1'b0, 1'b0);
    check_rx(nrx - 1, 8'hFF, 1'b0, 1'b0);

    repeat (60) @(posedge clk);
    send(8'h5A, 1'b0, t0);
    wait_until(t0 + 16 * 4 + 8);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_tx_ready", tx_ready, 1'b0);
    check("midrst_rx_valid", rx_valid, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after", tx_ready, 1'b1);
    repeat (400) @(posedge clk);
    #1;
    check("midrst_no_valid", rxd_q.size(), nrx);
    check("flags_only_with_valid", flag_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
